// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one data-memory request per load/store,
// waits for ack or timeout, and formats the result for the MEM/WB register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        flush_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] add_pc_in,
  input  logic [4:0]  addr_rd_in,
  input  logic        reg_file_write_in,
  input  logic [1:0]  select_mux_2_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] mem_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] add_pc_out,
  output logic [4:0]  addr_rd_out,
  output logic        reg_file_write_out,
  output logic [1:0]  select_mux_2_out,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        kill;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic        store_q;
  logic [31:0] alu_q;
  logic [31:0] pc_q;
  logic [4:0]  rd_q;
  logic        rfw_q;
  logic [1:0]  sel_q;

  logic        access;
  logic        aligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted;
  logic        sign_ext;
  logic [31:0] load_val;
  logic [7:0]  next_cnt;
  logic        timeout_hit;

  assign stall_out   = (state == BUSY);
  assign access      = mem_read_in | mem_write_in;
  assign next_cnt    = wait_cnt + 8'd1;
  assign timeout_hit = (next_cnt == TIMEOUT_CNT);

  // Size code 11 falls into the word case alongside 10.
  always_comb begin
    aligned = 1'b1;
    be_c    = 4'b1111;
    wdata_c = store_data_in;
    case (funct3_in[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr_in[1:0];
        wdata_c = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        aligned = ~addr_in[0];
        be_c    = 4'b0011 << addr_in[1:0];
        wdata_c = {2{store_data_in[15:0]}};
      end
      default: aligned = (addr_in[1:0] == 2'b00);
    endcase
  end

  assign shifted  = dmem_rdata >> {offset_q, 3'b000};
  assign sign_ext = ~funct3_q[2];

  always_comb begin
    load_val = dmem_rdata;
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      wait_cnt           <= 8'd0;
      kill               <= 1'b0;
      funct3_q           <= 3'd0;
      offset_q           <= 2'd0;
      store_q            <= 1'b0;
      alu_q              <= 32'd0;
      pc_q               <= 32'd0;
      rd_q               <= 5'd0;
      rfw_q              <= 1'b0;
      sel_q              <= 2'd0;
      dmem_req           <= 1'b0;
      dmem_we            <= 1'b0;
      dmem_addr          <= 32'd0;
      dmem_wdata         <= 32'd0;
      dmem_be            <= 4'd0;
      valid_out          <= 1'b0;
      mem_out            <= 32'd0;
      alu_result_out     <= 32'd0;
      add_pc_out         <= 32'd0;
      addr_rd_out        <= 5'd0;
      reg_file_write_out <= 1'b0;
      select_mux_2_out   <= 2'd0;
      misaligned_out     <= 1'b0;
      bus_error_out      <= 1'b0;
    end else begin
      valid_out      <= 1'b0;
      misaligned_out <= 1'b0;
      bus_error_out  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in && !flush_in) begin
            if (!access || !aligned) begin
              valid_out          <= 1'b1;
              mem_out            <= 32'd0;
              alu_result_out     <= alu_result_in;
              add_pc_out         <= add_pc_in;
              addr_rd_out        <= addr_rd_in;
              select_mux_2_out   <= select_mux_2_in;
              reg_file_write_out <= reg_file_write_in & !access;
              misaligned_out     <= access;
            end else begin
              state      <= BUSY;
              wait_cnt   <= 8'd0;
              kill       <= 1'b0;
              funct3_q   <= funct3_in;
              offset_q   <= addr_in[1:0];
              store_q    <= mem_write_in;
              alu_q      <= alu_result_in;
              pc_q       <= add_pc_in;
              rd_q       <= addr_rd_in;
              rfw_q      <= reg_file_write_in;
              sel_q      <= select_mux_2_in;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write_in;
              dmem_addr  <= {addr_in[31:2], 2'b00};
              dmem_wdata <= wdata_c;
              dmem_be    <= be_c;
            end
          end
        end
        BUSY: begin
          if (flush_in) kill <= 1'b1;
          // An ack arriving on the timeout cycle takes priority over the bus error.
          if (dmem_ack || timeout_hit) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            kill     <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (!kill && !flush_in) begin
              valid_out        <= 1'b1;
              alu_result_out   <= alu_q;
              add_pc_out       <= pc_q;
              addr_rd_out      <= rd_q;
              select_mux_2_out <= sel_q;
              if (dmem_ack) begin
                mem_out            <= store_q ? 32'd0 : load_val;
                reg_file_write_out <= rfw_q;
              end else begin
                mem_out            <= 32'd0;
                reg_file_write_out <= 1'b0;
                bus_error_out      <= 1'b1;
              end
            end
          end else begin
            wait_cnt <= next_cnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT=4): expected MEM/WB results are queued
// at issue time and compared when valid_out pulses.
module tb_mem_access_stage;

  localparam int W = 106;

  logic        clk;
  logic        reset;
  logic        valid_in, flush_in, mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, alu_result_in, store_data_in, add_pc_in;
  logic [4:0]  addr_rd_in;
  logic        reg_file_write_in;
  logic [1:0]  select_mux_2_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall_out, valid_out;
  logic [31:0] mem_out, alu_result_out, add_pc_out;
  logic [4:0]  addr_rd_out;
  logic        reg_file_write_out;
  logic [1:0]  select_mux_2_out;
  logic        misaligned_out, bus_error_out;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .flush_in(flush_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .funct3_in(funct3_in),
    .addr_in(addr_in), .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .add_pc_in(add_pc_in), .addr_rd_in(addr_rd_in), .reg_file_write_in(reg_file_write_in),
    .select_mux_2_in(select_mux_2_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_out(stall_out),
    .valid_out(valid_out), .mem_out(mem_out), .alu_result_out(alu_result_out),
    .add_pc_out(add_pc_out), .addr_rd_out(addr_rd_out),
    .reg_file_write_out(reg_file_write_out), .select_mux_2_out(select_mux_2_out),
    .misaligned_out(misaligned_out), .bus_error_out(bus_error_out)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] obs_vec;
  logic [69:0]  bus_vec;
  logic [180:0] all_vec;
  assign obs_vec = {mem_out, alu_result_out, add_pc_out, addr_rd_out, reg_file_write_out,
                    select_mux_2_out, misaligned_out, bus_error_out};
  assign bus_vec = {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be};
  assign all_vec = {valid_out, stall_out, bus_vec, obs_vec, 3'b000};

  logic [W-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int n_vo_exp = 0;
  int vo_total = 0;
  int stall_total = 0;
  int req_total = 0;

  always @(negedge clk) begin
    if (valid_out) vo_total++;
    if (stall_out) stall_total++;
    if (dmem_req)  req_total++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [31:0] m, input logic [31:0] a,
                                        input logic [31:0] p, input logic [4:0] r,
                                        input logic w, input logic [1:0] s,
                                        input logic mi, input logic be);
    return {m, a, p, r, w, s, mi, be};
  endfunction

  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
    n_vo_exp++;
  endtask

  // Driver tasks
  task automatic idle_inputs();
    valid_in = 0; flush_in = 0; mem_read_in = 0; mem_write_in = 0; funct3_in = 0;
    addr_in = 0; alu_result_in = 0; store_data_in = 0; add_pc_in = 0; addr_rd_in = 0;
    reg_file_write_in = 0; select_mux_2_in = 0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] pc,
                       input logic [4:0] rdi, input logic rfw, input logic [1:0] sel);
    valid_in = 1; mem_read_in = rd; mem_write_in = wr; funct3_in = f3; addr_in = addr;
    alu_result_in = addr; store_data_in = sd; add_pc_in = pc; addr_rd_in = rdi;
    reg_file_write_in = rfw; select_mux_2_in = sel;
  endtask

  // Presents one instruction for one cycle; returns 1 time unit after its accepting edge.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] pc,
                       input logic [4:0] rdi, input logic rfw, input logic [1:0] sel,
                       input logic fl);
    @(posedge clk); #1;
    drive(rd, wr, f3, addr, sd, pc, rdi, rfw, sel);
    flush_in = fl;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Holds ack low for 'waits' BUSY cycles, checking the request stays stable, then acks.
  task automatic ack_after(input int waits, input logic [31:0] rdata, input string tag);
    logic [69:0] snap;
    snap = bus_vec;
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
      check({tag, "_bus_stable"}, bus_vec, snap);
    end
    dmem_ack = 1; dmem_rdata = rdata;
    @(posedge clk); #1;
    dmem_ack = 0; dmem_rdata = 32'h0;
  endtask

  task automatic expect_out(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, valid_out, 1'b1);
    check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1'b1);
    if (exp_q.size() > 0) check(tag, obs_vec, exp_q.pop_front());
  endtask

  int s0;

  initial begin
    idle_inputs();
    dmem_ack = 0; dmem_rdata = 0;
    reset = 0;
    #2;
    check("reset_outputs", all_vec, 181'd0);
    @(posedge clk); #1;
    reset = 1;

    // Non-memory op, 1-cycle latency
    push(pack(32'h0, 32'h1234, 32'h104, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0));
    issue(0, 0, 3'b000, 32'h1234, 32'h0, 32'h104, 5'd5, 1'b1, 2'd0, 1'b0);
    expect_out("alu_op");

    // lb 0x103 -> sign-extended top byte
    push(pack(32'hFFFF_FF80, 32'h103, 32'h108, 5'd6, 1'b1, 2'd1, 1'b0, 1'b0));
    issue(1, 0, 3'b000, 32'h103, 32'h0, 32'h108, 5'd6, 1'b1, 2'd1, 1'b0);
    @(negedge clk);
    check("lb_req", {dmem_req, dmem_we, stall_out, dmem_addr}, {3'b101, 32'h100});
    ack_after(0, 32'h80FF_FF00, "lb");
    expect_out("lb");

    // sh 0x22 with 3 wait cycles
    push(pack(32'h0, 32'h22, 32'h10C, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    s0 = stall_total;
    issue(0, 1, 3'b001, 32'h22, 32'h0000_ABCD, 32'h10C, 5'd0, 1'b0, 2'd0, 1'b0);
    check("sh_bus", bus_vec, {1'b1, 1'b1, 32'h20, 32'hABCD_ABCD, 4'b1100});
    valid_in = 1;  // a waiting instruction must be ignored while BUSY
    ack_after(3, 32'h0, "sh");
    valid_in = 0;
    expect_out("sh");
    check("sh_stall_cycles", stall_total - s0, 4);

    // sb 0x1
    push(pack(32'h0, 32'h1, 32'h110, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    issue(0, 1, 3'b000, 32'h1, 32'h1234_565A, 32'h110, 5'd0, 1'b0, 2'd0, 1'b0);
    check("sb_bus", bus_vec, {1'b1, 1'b1, 32'h0, 32'h5A5A_5A5A, 4'b0010});
    ack_after(0, 32'h0, "sb");
    expect_out("sb");

    // sw 0x8
    push(pack(32'h0, 32'h8, 32'h114, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    issue(0, 1, 3'b010, 32'h8, 32'hDEAD_BEEF, 32'h114, 5'd0, 1'b0, 2'd0, 1'b0);
    check("sw_bus", bus_vec, {1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'b1111});
    ack_after(1, 32'h0, "sw");
    expect_out("sw");

    // lh 0x4 -> sign-extended low half
    push(pack(32'hFFFF_8123, 32'h4, 32'h118, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0));
    issue(1, 0, 3'b001, 32'h4, 32'h0, 32'h118, 5'd7, 1'b1, 2'd1, 1'b0);
    ack_after(2, 32'h0000_8123, "lh");
    expect_out("lh");

    // lhu 0x22 -> zero-extended upper half
    push(pack(32'h0000_F00D, 32'h22, 32'h11C, 5'd8, 1'b1, 2'd1, 1'b0, 1'b0));
    issue(1, 0, 3'b101, 32'h22, 32'h0, 32'h11C, 5'd8, 1'b1, 2'd1, 1'b0);
    ack_after(1, 32'hF00D_1234, "lhu");
    expect_out("lhu");

    // lbu 0x81, ack on the 4th BUSY cycle: ack beats timeout
    push(pack(32'h0000_0099, 32'h81, 32'h120, 5'd9, 1'b1, 2'd1, 1'b0, 1'b0));
    issue(1, 0, 3'b100, 32'h81, 32'h0, 32'h120, 5'd9, 1'b1, 2'd1, 1'b0);
    ack_after(3, 32'h0000_9900, "lbu_to_edge");
    expect_out("lbu_to_edge");

    // Misaligned lw 0x41 and lh 0x23
    push(pack(32'h0, 32'h41, 32'h124, 5'd10, 1'b0, 2'd1, 1'b1, 1'b0));
    s0 = req_total;
    issue(1, 0, 3'b010, 32'h41, 32'h0, 32'h124, 5'd10, 1'b1, 2'd1, 1'b0);
    expect_out("lw_misaligned");
    check("lw_misaligned_noreq", {stall_out, dmem_req, 32'(req_total - s0)}, 34'd0);
    push(pack(32'h0, 32'h23, 32'h128, 5'd11, 1'b0, 2'd1, 1'b1, 1'b0));
    issue(1, 0, 3'b001, 32'h23, 32'h0, 32'h128, 5'd11, 1'b1, 2'd1, 1'b0);
    expect_out("lh_misaligned");

    // Timeout with no ack
    push(pack(32'h0, 32'h80, 32'h12C, 5'd12, 1'b0, 2'd1, 1'b0, 1'b1));
    s0 = req_total;
    issue(1, 0, 3'b010, 32'h80, 32'h0, 32'h12C, 5'd12, 1'b1, 2'd1, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    expect_out("timeout");
    check("timeout_req_cycles", req_total - s0, 4);

    // Flush in IDLE: nothing comes out
    issue(1, 0, 3'b010, 32'h40, 32'h0, 32'h130, 5'd13, 1'b1, 2'd1, 1'b1);
    @(negedge clk);
    check("flush_idle", {valid_out, stall_out, dmem_req}, 3'b000);

    // Flush in BUSY, next instruction held upstream
    issue(1, 0, 3'b010, 32'h40, 32'h0, 32'h134, 5'd14, 1'b1, 2'd1, 1'b0);
    flush_in = 1;
    drive(0, 0, 3'b000, 32'h5555, 32'h0, 32'h138, 5'd15, 1'b1, 2'd3);
    @(posedge clk); #1;
    flush_in = 0; dmem_ack = 1; dmem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    dmem_ack = 0;
    @(negedge clk);
    check("flush_busy_suppressed", {valid_out, stall_out}, 2'b00);
    push(pack(32'h0, 32'h5555, 32'h138, 5'd15, 1'b1, 2'd3, 1'b0, 1'b0));
    @(posedge clk); #1;
    idle_inputs();
    expect_out("held_after_flush");

    // Reset mid-BUSY, then a late ack
    issue(1, 0, 3'b010, 32'h44, 32'h0, 32'h13C, 5'd16, 1'b1, 2'd1, 1'b0);
    @(negedge clk);
    check("pre_reset_busy", {dmem_req, stall_out}, 2'b11);
    #2 reset = 0;
    #1 check("async_reset_outputs", all_vec, 181'd0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_ack = 0;
    @(negedge clk);
    check("late_ack_ignored", {valid_out, stall_out, dmem_req}, 3'b000);

    repeat (3) @(posedge clk);
    #1;
    check("valid_pulse_count", vo_total, n_vo_exp);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of BUSY cycles without dmem_ack before the access is abandoned (range 1..255).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 valid_in  in  1  upstream instruction is present on the *_in fields.
REQ-005 flush_in  in  1  discard the instruction in this stage.
REQ-006 mem_read_in, mem_write_in  in  1 each  load or store request; both high is treated as a store.
REQ-007 funct3_in  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; sb/sh/sw for stores; size code 11 is treated as word.
REQ-008 addr_in  in  32  byte address; alu_result_in  in  32  ALU result; store_data_in  in  32  store data; add_pc_in  in  32  PC+4.
REQ-009 addr_rd_in  in  5; reg_file_write_in  in  1; select_mux_2_in  in  2: writeback controls.
REQ-010 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 (addr with [1:0]=00); dmem_wdata  out  32; dmem_be  out  4: data-memory request.
REQ-011 dmem_rdata  in  32; dmem_ack  in  1: data-memory response.
REQ-012 stall_out  out  1  hold the upstream stage.
REQ-013 valid_out  out  1; mem_out  out  32; alu_result_out  out  32; add_pc_out  out  32; addr_rd_out  out  5; reg_file_write_out  out  1; select_mux_2_out  out  2: results for the MEM/WB register.
REQ-014 misaligned_out  out  1; bus_error_out  out  1: exception flags, valid only with valid_out.

Function
REQ-015 The FSM SHALL have two states, IDLE and BUSY; stall_out = (state == BUSY), driven combinationally.
REQ-016 IDLE, valid_in=1, flush_in=0, no access: next cycle valid_out=1, with the fields copied and mem_out=0; latency is 1 cycle.
REQ-017 IDLE, aligned access accepted: all fields and the byte offset are captured; the state moves to BUSY; dmem_req=1 from the next cycle onward.
REQ-018 Alignment rules: halfword requires addr[0]=0; word requires addr[1:0]=00; bytes are always aligned.
REQ-019 Misaligned access: no dmem_req; next cycle valid_out=1, misaligned_out=1, reg_file_write_out=0.
REQ-020 While in BUSY: dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be SHALL stay stable, and valid_in is ignored.
REQ-021 Byte enables: sb drives 0001<<addr[1:0]; sh drives 0011<<addr[1:0]; sw drives 1111. Write data: sb drives {4{byte}}; sh drives {2{half}}; sw drives the data unchanged.
REQ-022 dmem_ack is sampled only in BUSY, earliest on the first BUSY cycle; dmem_rdata is captured on the ack cycle.
REQ-023 On ack: next cycle dmem_req=0, state=IDLE, valid_out=1. The minimum latency is 2 cycles from acceptance to valid_out.
REQ-024 Load data: select byte/half at offset addr[1:0]; sign-extend when funct3[2]=0, zero-extend otherwise; lw passes the word unchanged.
REQ-025 For a store, mem_out SHALL be 0.
REQ-026 An 8-bit wait counter is cleared on acceptance and increments each BUSY cycle without ack.
REQ-027 Timeout: when the counter reaches TIMEOUT, dmem_req drops, the state returns to IDLE, and next cycle valid_out=1, bus_error_out=1, reg_file_write_out=0.
REQ-028 An ack in the same cycle as the timeout SHALL win; bus_error_out stays 0.
REQ-029 flush_in in IDLE: the input is discarded and no valid_out is produced.
REQ-030 flush_in in BUSY: the bus transaction still completes (ack or timeout), but valid_out is suppressed; the kill flag is cleared on return to IDLE.
REQ-031 valid_out and the flags SHALL be one-cycle pulses; the data fields hold their last values otherwise.

Reset
REQ-032 reset=0 SHALL force IDLE, counter=0, kill=0, and every output to 0 immediately, independent of clk.
REQ-033 Reset during BUSY SHALL abandon the access; a late dmem_ack after reset release is ignored because the state is IDLE.

Verification
REQ-034 Input lb, addr=0x103, rdata=0x80FF_FF00, ack on the 1st BUSY cycle -> valid_out 2 cycles after acceptance, mem_out=0xFFFF_FF80.
REQ-035 Input sh, addr=0x22, data=0x0000_ABCD, ack after 3 waits -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_addr=0x20, stall_out high for 4 cycles.
REQ-036 Input lw, addr=0x41 -> no dmem_req, valid_out=1 with misaligned_out=1 and reg_file_write_out=0 one cycle later.
REQ-037 TIMEOUT=4, no ack -> dmem_req high for 4 cycles, then valid_out=1 with bus_error_out=1; ack coincident with the 4th cycle -> bus_error_out=0.
REQ-038 flush_in during BUSY, then ack -> no valid_out; the held next instruction (non-memory) is accepted the cycle after and produces valid_out one cycle later.
REQ-039 reset=0 mid-BUSY -> all outputs 0 asynchronously; ack one cycle after release produces no valid_out.
